adc_sar_conv_controller: RTL and testbench

- Synchronous SAR conversion sequencer, directly downstream of the start-pulse edge-detect stage; consumes that stage's `ena_out` as its `ena_in`.
- On each rising edge of `ena_in`: drives the sample switch for a fixed window, then runs an N-bit successive-approximation search against the comparator, driving the DAC code.
- Publishes the result with a one-cycle valid strobe.

---
 rtl/adc_sar_conv_controller.sv | 126 ++++++++++++
 tb/tb_adc_sar_conv_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/adc_sar_conv_controller.sv
// SAR conversion sequencer: synchronises a start request, samples, then runs an
// N-bit successive-approximation search. Optional macro: ADC_SAR_CONT_MODE_EN.
module adc_sar_conv_controller #(
  parameter int RESOLUTION    = 8,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_in,
  input  logic                  comparator_in,
`ifdef ADC_SAR_CONT_MODE_EN
  input  logic                  cont_mode,
`endif
  output logic                  sample_out,
  output logic [RESOLUTION-1:0] dac_code,
  output logic [RESOLUTION-1:0] result,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int PTR_W = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAMPLE  = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [7:0]       CNT_LOAD = 8'(SAMPLE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_MSB  = PTR_W'(RESOLUTION - 1);

  logic [2:0]            sync_q, sync_d;
  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [RESOLUTION-1:0] dac_q, dac_d;
  logic [RESOLUTION-1:0] result_q, result_d;
  logic                  start_evt;
  logic                  restart;

  // sync_q[1] is the metastability-safe copy; sync_q[2] delays it for edge detect.
  assign sync_d    = {sync_q[1:0], ena_in};
  assign start_evt = sync_q[1] & ~sync_q[2];

`ifdef ADC_SAR_CONT_MODE_EN
  assign restart = cont_mode;
`else
  assign restart = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that keeps this block purely combinational (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    dac_d    = dac_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d = ST_SAMPLE;
          cnt_d   = CNT_LOAD;
          dac_d   = '0;
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == 8'd0) begin
          state_d                = ST_CONVERT;
          dac_d                  = '0;
          dac_d[RESOLUTION-1]    = 1'b1;
          ptr_d                  = PTR_MSB;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CONVERT: begin
        // Keep the trial bit only if Vin is at or above the current DAC level.
        dac_d[ptr_q] = comparator_in;
        if (ptr_q != '0) begin
          dac_d[ptr_q - 1'b1] = 1'b1;
          ptr_d               = ptr_q - 1'b1;
        end else begin
          state_d  = ST_DONE;
          result_d = dac_d;
        end
      end
      ST_DONE: begin
        dac_d = '0;
        if (restart) begin
          state_d = ST_SAMPLE;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      dac_q    <= dac_d;
      result_q <= result_d;
    end
  end

  assign sample_out   = (state_q == ST_SAMPLE);
  assign busy         = (state_q == ST_SAMPLE) || (state_q == ST_CONVERT);
  assign result_valid = (state_q == ST_DONE);
  assign dac_code     = dac_q;
  assign result       = result_q;

endmodule

// File: tb/tb_adc_sar_conv_controller.sv
// Self-checking bench: a default 8-bit instance and a 4-bit/1-sample instance,
// each driven by an ideal comparator and compared against a timeline model.
module tb_adc_sar_conv_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena0, cmp0, sample0, rv0, busy0;
  logic [7:0] dac0, res0;
  logic       ena4, cmp4, sample4, rv4, busy4;
  logic [3:0] dac4, res4;
`ifdef ADC_SAR_CONT_MODE_EN
  logic       cont_mode;
`endif

  logic [7:0] vin0;
  logic [3:0] vin4;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         prev_res[2];

  always #5 clk = ~clk;

  adc_sar_conv_controller u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .ena_in        (ena0),
    .comparator_in (cmp0),
`ifdef ADC_SAR_CONT_MODE_EN
    .cont_mode     (cont_mode),
`endif
    .sample_out    (sample0),
    .dac_code      (dac0),
    .result        (res0),
    .result_valid  (rv0),
    .busy          (busy0)
  );

  adc_sar_conv_controller #(.RESOLUTION(4), .SAMPLE_CYCLES(1)) u_dut4 (
    .clk           (clk),
    .rst           (rst),
    .ena_in        (ena4),
    .comparator_in (cmp4),
`ifdef ADC_SAR_CONT_MODE_EN
    .cont_mode     (1'b0),
`endif
    .sample_out    (sample4),
    .dac_code      (dac4),
    .result        (res4),
    .result_valid  (rv4),
    .busy          (busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let the ideal comparator react to the new DAC code.
  task automatic tick();
    @(posedge clk);
    #1;
    cmp0 = (vin0 >= dac0);
    cmp4 = (vin4 >= dac4);
  endtask

  // mode 0: short pulse, 1: second edge mid-conversion, 2: request held high.
  task automatic run_conv(input int sel, input logic [7:0] vin_in, input int mode,
                          input string tag);
    int n, s, last, k, b, exp_dac, v;
    logic o_sample, o_busy, o_rv;
    logic [7:0] o_dac, o_res;
    n    = sel ? 4 : 8;
    s    = sel ? 1 : 4;
    last = s + n + 2;
    v    = sel ? int'(vin_in & 8'h0F) : int'(vin_in);
    if (sel != 0) begin vin4 = v[3:0]; ena4 = 1'b1; end
    else          begin vin0 = v[7:0]; ena0 = 1'b1; end
    for (int e = 0; e <= last + 2; e++) begin
      tick();
      o_sample = sel ? sample4 : sample0;
      o_busy   = sel ? busy4   : busy0;
      o_rv     = sel ? rv4     : rv0;
      o_dac    = sel ? {4'b0, dac4} : dac0;
      o_res    = sel ? {4'b0, res4} : res0;
      if (e >= s + 2 && e <= s + n + 1) begin
        k       = e - (s + 2);
        b       = n - 1 - k;
        exp_dac = ((v >> (b + 1)) << (b + 1)) | (1 << b);
      end else if (e == last) begin
        exp_dac = v;
      end else begin
        exp_dac = 0;
      end
      if (e >= last) prev_res[sel] = v;
      check($sformatf("%s e%0d sample_out", tag, e), 32'(o_sample), 32'(e >= 2 && e <= s + 1));
      check($sformatf("%s e%0d busy", tag, e), 32'(o_busy), 32'(e >= 2 && e <= s + n + 1));
      check($sformatf("%s e%0d result_valid", tag, e), 32'(o_rv), 32'(e == last));
      check($sformatf("%s e%0d dac_code", tag, e), 32'(o_dac), exp_dac);
      check($sformatf("%s e%0d result", tag, e), 32'(o_res), prev_res[sel]);
      if (e == 2 && mode != 2) begin ena0 = 1'b0; ena4 = 1'b0; end
      if (mode == 1 && e == 8)  ena0 = 1'b1;
      if (mode == 1 && e == 10) ena0 = 1'b0;
    end
    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("%s idle%0d busy", tag, e), 32'(sel ? busy4 : busy0), 32'd0);
      check($sformatf("%s idle%0d result_valid", tag, e), 32'(sel ? rv4 : rv0), 32'd0);
    end
    ena0 = 1'b0;
    ena4 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst  = 1'b1;
    ena0 = 1'b0; ena4 = 1'b0;
    cmp0 = 1'b0; cmp4 = 1'b0;
    vin0 = '0;   vin4 = '0;
    prev_res[0] = 0;
    prev_res[1] = 0;
`ifdef ADC_SAR_CONT_MODE_EN
    cont_mode = 1'b0;
`endif
    #12;
    check("reset sample_out", 32'(sample0), 32'd0);
    check("reset dac_code", 32'(dac0), 32'd0);
    check("reset result", 32'(res0), 32'd0);
    check("reset result_valid", 32'(rv0), 32'd0);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset4 busy", 32'(busy4), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    run_conv(0, 8'hA5, 0, "conv_a5");
    run_conv(0, 8'h00, 0, "conv_00");
    run_conv(0, 8'hFF, 0, "conv_ff");
    run_conv(0, 8'h3D, 1, "retrigger");
    run_conv(0, 8'h5A, 2, "held_high");
    for (int r = 0; r < 4; r++) run_conv(0, 8'($urandom_range(0, 255)), 0, $sformatf("rand%0d", r));
    run_conv(1, 8'h09, 0, "r4_09");
    for (int r = 0; r < 3; r++) run_conv(1, 8'($urandom_range(0, 15)), 0, $sformatf("r4_rand%0d", r));

    // Abort during the bit-5 trial; the reset must act without a clock edge.
    vin0 = 8'h3C;
    ena0 = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      if (e == 2) ena0 = 1'b0;
    end
    check("pre-abort busy", 32'(busy0), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("abort sample_out", 32'(sample0), 32'd0);
    check("abort dac_code", 32'(dac0), 32'd0);
    check("abort result", 32'(res0), 32'd0);
    check("abort result_valid", 32'(rv0), 32'd0);
    check("abort busy", 32'(busy0), 32'd0);
    prev_res[0] = 0;
    prev_res[1] = 0;
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      check($sformatf("post-abort %0d result_valid", e), 32'(rv0), 32'd0);
      check($sformatf("post-abort %0d busy", e), 32'(busy0), 32'd0);
    end
    run_conv(0, 8'h3C, 0, "after_abort");

`ifdef ADC_SAR_CONT_MODE_EN
    vin0      = 8'h55;
    cont_mode = 1'b1;
    ena0      = 1'b1;
    for (int e = 0; e <= 50; e++) begin
      tick();
      check($sformatf("cont e%0d result_valid", e), 32'(rv0), 32'(e == 14 || e == 27 || e == 40));
      if (e == 14 || e == 27 || e == 40)
        check($sformatf("cont e%0d result", e), 32'(res0), 32'h55);
      if (e == 15 || e == 28)
        check($sformatf("cont e%0d sample_out", e), 32'(sample0), 32'd1);
      if (e >= 41)
        check($sformatf("cont e%0d busy", e), 32'(busy0), 32'd0);
      if (e == 2)  ena0 = 1'b0;
      if (e == 30) cont_mode = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
